// File: rtl/mem_pkg.sv
// Shared parameters and state encoding for the main-memory line-transfer controller.
package mem_pkg;

    localparam int unsigned DATA_WIDTH     = 32;
    localparam int unsigned ADDR_WIDTH     = 16;
    localparam int unsigned WORDS_PER_LINE = 4;
    localparam int unsigned OFFSET_W       = $clog2(WORDS_PER_LINE);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2
    } state_e;

endpackage

// File: rtl/mem_line_ctrl.sv
// Sequences one cache-line writeback or fill as single-word accesses on the data RAM ports,
// returning fill data on a valid/ready stream that relies on the RAM holding its read output.
module mem_line_ctrl #(
    parameter int unsigned DATA_WIDTH     = mem_pkg::DATA_WIDTH,
    parameter int unsigned ADDR_WIDTH     = mem_pkg::ADDR_WIDTH,
    parameter int unsigned WORDS_PER_LINE = mem_pkg::WORDS_PER_LINE
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic                  wdata_valid,
    output logic                  wdata_ready,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic                  rdata_valid,
    input  logic                  rdata_ready,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  rdata_last,
    output logic                  done,
    output logic                  ram_w_en,
    output logic [ADDR_WIDTH-1:0] ram_w_addr,
    output logic [DATA_WIDTH-1:0] ram_w_data,
    output logic                  ram_r_en,
    output logic [ADDR_WIDTH-1:0] ram_r_addr,
    input  logic [DATA_WIDTH-1:0] ram_r_data
);
    import mem_pkg::*;

    localparam int unsigned OFF_W = $clog2(WORDS_PER_LINE);
    localparam int unsigned CNT_W = OFF_W + 1;
    localparam logic [OFF_W-1:0]      LAST_IDX = OFF_W'(WORDS_PER_LINE - 1);
    localparam logic [ADDR_WIDTH-1:0] TAG_MASK = ~ADDR_WIDTH'(WORDS_PER_LINE - 1);

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] base_q, base_d;
    logic [OFF_W-1:0]      wcnt_q, wcnt_d;
    logic [CNT_W-1:0]      issued_q, issued_d;
    logic                  rvalid_q, rvalid_d;
    logic                  rlast_q, rlast_d;
    logic                  req_ready_q, req_ready_d;
    logic                  wdata_ready_q, wdata_ready_d;
    logic                  ram_w_en_q, ram_w_en_d;
    logic [ADDR_WIDTH-1:0] ram_w_addr_q, ram_w_addr_d;
    logic [DATA_WIDTH-1:0] ram_w_data_q, ram_w_data_d;
    logic                  done_w_q, done_w_d;

    logic req_hs, w_hs, r_hs, ren;

    assign req_hs = req_valid & req_ready_q;
    assign w_hs   = wdata_valid & wdata_ready_q;
    assign r_hs   = rvalid_q & rdata_ready;
    // Issue only when the output slot is free or being drained; a stalled beat keeps the RAM output frozen.
    assign ren    = (state_q == READ) & ~issued_q[OFF_W] & (~rvalid_q | rdata_ready);

    assign req_ready   = req_ready_q;
    assign wdata_ready = wdata_ready_q;
    assign rdata_valid = rvalid_q;
    assign rdata_last  = rlast_q;
    assign rdata       = ram_r_data;
    assign ram_w_en    = ram_w_en_q;
    assign ram_w_addr  = ram_w_addr_q;
    assign ram_w_data  = ram_w_data_q;
    assign ram_r_en    = ren;
    assign ram_r_addr  = base_q | ADDR_WIDTH'(issued_q[OFF_W-1:0]);
    assign done        = done_w_q | (r_hs & rlast_q);

    // State and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            base_q        <= '0;
            wcnt_q        <= '0;
            issued_q      <= '0;
            rvalid_q      <= 1'b0;
            rlast_q       <= 1'b0;
            req_ready_q   <= 1'b0;
            wdata_ready_q <= 1'b0;
            ram_w_en_q    <= 1'b0;
            ram_w_addr_q  <= '0;
            ram_w_data_q  <= '0;
            done_w_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            base_q        <= base_d;
            wcnt_q        <= wcnt_d;
            issued_q      <= issued_d;
            rvalid_q      <= rvalid_d;
            rlast_q       <= rlast_d;
            req_ready_q   <= req_ready_d;
            wdata_ready_q <= wdata_ready_d;
            ram_w_en_q    <= ram_w_en_d;
            ram_w_addr_q  <= ram_w_addr_d;
            ram_w_data_q  <= ram_w_data_d;
            done_w_q      <= done_w_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (req_hs) state_d = req_write ? WRITE : READ;
            WRITE:   if (w_hs && (wcnt_q == LAST_IDX)) state_d = IDLE;
            READ:    if (r_hs && rlast_q) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Counters, RAM strobes and handshake outputs.
    always_comb begin
        base_d        = base_q;
        wcnt_d        = wcnt_q;
        issued_d      = issued_q;
        rvalid_d      = rvalid_q;
        rlast_d       = rlast_q;
        ram_w_en_d    = 1'b0;
        ram_w_addr_d  = ram_w_addr_q;
        ram_w_data_d  = ram_w_data_q;
        done_w_d      = 1'b0;
        req_ready_d   = (state_d == IDLE);
        wdata_ready_d = (state_d == WRITE);

        if (req_hs) begin
            base_d   = req_addr & TAG_MASK;
            wcnt_d   = '0;
            issued_d = '0;
        end

        if (w_hs) begin
            ram_w_en_d   = 1'b1;
            ram_w_addr_d = base_q | ADDR_WIDTH'(wcnt_q);
            ram_w_data_d = wdata;
            wcnt_d       = wcnt_q + OFF_W'(1);
            done_w_d     = (wcnt_q == LAST_IDX);
        end

        // The last flag follows the index of the beat that the next cycle will present.
        if (ren) begin
            issued_d = issued_q + CNT_W'(1);
            rvalid_d = 1'b1;
            rlast_d  = (issued_q[OFF_W-1:0] == LAST_IDX);
        end else if (r_hs) begin
            rvalid_d = 1'b0;
            rlast_d  = 1'b0;
        end
    end

endmodule

// File: doc/mem_line_ctrl.md
# mem_line_ctrl

Line-transfer controller that drives the main-memory data RAM's write and read ports on behalf of the coherence interconnect. It accepts one cache-line request at a time: a writeback or a fill. Each line is sequenced as WORDS_PER_LINE single-word RAM accesses. Read data returns on a valid/ready stream with full throughput and backpressure, exploiting the RAM's 1-cycle registered read and its hold-on-idle output.

## Interface
- DATA_WIDTH, 32, word width; equals RAM DATA_WIDTH
- ADDR_WIDTH, 16, word address width; equals RAM ADDR_WIDTH
- WORDS_PER_LINE, 4, words per cache line; power of 2, ≥2
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- req_valid  in  1  line request valid
- req_ready  out  1  controller idle, request accepted on valid&ready
- req_write  in  1  1 = writeback (line to RAM), 0 = fill (line from RAM)
- req_addr  in  ADDR_WIDTH  word address of line; low log2(WORDS_PER_LINE) bits ignored
- wdata_valid  in  1  write beat valid
- wdata_ready  out  1  write beat accepted
- wdata  in  DATA_WIDTH  write beat
- rdata_valid  out  1  read beat valid
- rdata_ready  in  1  consumer accepts read beat
- rdata  out  DATA_WIDTH  read beat (= ram_r_data)
- rdata_last  out  1  final beat of line
- done  out  1  one-cycle pulse, line transfer complete
- ram_w_en / ram_w_addr / ram_w_data  out  1 / ADDR_WIDTH / DATA_WIDTH  to RAM write port
- ram_r_en / ram_r_addr  out  1 / ADDR_WIDTH  to RAM read port
- ram_r_data  in  DATA_WIDTH  from RAM, valid cycle after ram_r_en, held while ram_r_en low

## Operation
- States: IDLE, WRITE, READ.
- IDLE: req_ready=1. On handshake, latch base = req_addr with low bits zeroed, clear beat counter cnt. Go to WRITE if req_write=1, else READ.
- WRITE: wdata_ready=1. Each wdata handshake registers ram_w_en=1, ram_w_addr=base|cnt, ram_w_data=wdata, then cnt++. On the handshake with cnt=WORDS_PER_LINE-1, return to IDLE. done pulses with that beat's ram_w_en.
- READ: ram_r_en = (issued<WORDS_PER_LINE) & (!rdata_valid | rdata_ready), combinational. ram_r_addr=base|issued.
  - rdata_valid is registered and set the cycle after any ram_r_en.
  - rdata_valid clears on handshake when no new issue.
  - rdata_last=1 while the valid beat is index WORDS_PER_LINE-1.
  - Handshake of the last beat: done=1, return to IDLE.
- Address arithmetic: counter width log2(WORDS_PER_LINE), OR-ed into base. It never carries into the line tag.
- rdata is unchanged while rdata_valid & !rdata_ready, because ram_r_en is low.

## Timing
- Reset values: req_ready=0 during reset, state IDLE; all other outputs 0.
- Reset mid-transfer: abort immediately to IDLE with no further RAM strobes. Words already written stay in RAM. Any in-flight read beat is dropped.
- Write: handshake at cycle t → ram_w_en at t+1. One beat per cycle sustained. req_ready returns at t+1 after the last beat.
- Read: accept at t → first ram_r_en at t+1 → rdata_valid at t+2. With rdata_ready held high, one beat per cycle. The last beat handshake is at t+1+WORDS_PER_LINE, and req_ready is high the next cycle.
- Read-after-write: the last write strobe occurs in the cycle a new request can be accepted. The first read strobe comes a cycle later, so fresh data is seen; no bypass is needed.
- wdata_valid outside WRITE is ignored (wdata_ready=0). rdata_ready outside a valid beat has no effect.

## Structure
- Shared package mem_pkg:
  - DATA_WIDTH and ADDR_WIDTH defaults
  - WORDS_PER_LINE and derived OFFSET_W = log2(WORDS_PER_LINE)
  - state enum {IDLE, WRITE, READ}
- Single module; no sub-module is natural. The RAM is instantiated beside it at subsystem level, not inside.

## Test plan
- Writeback req_addr=0x0013 (base 0x0010), beats 0xA0..0xA3 back-to-back → ram_w_en 4 consecutive cycles at 0x0010..0x0013, done with the last strobe.
- Fill req_addr=0x0010 after that writeback, rdata_ready=1 → rdata 0xA0,0xA1,0xA2,0xA3 on consecutive cycles, rdata_last on 0xA3, first beat 2 cycles after accept.
- Fill with rdata_ready toggling 1,0,0,1,… → no ram_r_en while stalled, rdata stable during stall, all 4 beats exactly once in order.
- Writeback with wdata_valid gaps (valid every 3rd cycle) → exactly 4 strobes, correct addresses, no strobe in gap cycles.
- Line at top of memory, req_addr=0xFFFF → accesses 0xFFFC..0xFFFF, no wrap into 0x0000.
- Assert rst after 2 write beats → outputs 0 immediately, only 2 words modified. Next request after rst deassertion is processed normally from cnt=0.
